// File: rtl/serial_ctrl.sv
// UART bridge for the dm stage: decodes the serial data/status addresses, sequences rdn/wrn
// and buffers received bytes in a small RX FIFO; Busy stalls stores while a transfer is running.
module serial_ctrl #(
  parameter logic [15:0] DATA_ADDR  = 16'hBF00,
  parameter logic [15:0] STAT_ADDR  = 16'hBF01,
  parameter int          RD_CYCLES  = 2,
  parameter int          WR_CYCLES  = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [15:0] DataOut,
  output logic        Busy,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic [7:0]  BusOut,
  output logic        BusOe,
  input  logic [7:0]  BusIn
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 8;
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RX_STROBE,
    RX_RECOVER,
    TX_SETUP,
    TX_STROBE,
    TX_HOLD,
    TX_WAIT_TBRE,
    TX_WAIT_TSRE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_tx;
  logic            r_rdn;
  logic            r_wrn;
  logic            r_bus_oe;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_count;

  logic            w_wr_hit;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_rx_avail;
  logic            w_tx_ready;
  logic [15:0]     w_dout;
  logic            w_unused_ok;

  assign w_wr_hit    = MemWrite && (Addr == DATA_ADDR);
  assign w_accept    = w_wr_hit && (r_state == IDLE);
  assign w_push      = (r_state == RX_STROBE) && (r_cnt == RD_LAST);
  assign w_rx_avail  = (r_count != '0);
  assign w_pop       = MemRead && (Addr == DATA_ADDR) && w_rx_avail;
  assign w_full      = (r_count == FULL_CNT);
  assign w_tx_ready  = (r_state == IDLE) || (r_state == RX_STROBE) || (r_state == RX_RECOVER);
  assign w_unused_ok = &{1'b0, DataIn[15:8]};

  assign Busy    = w_wr_hit && (r_state != IDLE);
  assign rdn     = r_rdn;
  assign wrn     = r_wrn;
  assign BusOe   = r_bus_oe;
  assign BusOut  = r_tx;
  assign DataOut = w_dout;

  always_comb begin
    w_dout = '0;
    if (MemRead && (Addr == STAT_ADDR)) begin
      w_dout = {14'b0, w_rx_avail, w_tx_ready};
    end else if (w_pop) begin
      w_dout = {8'h00, r_mem[r_rp]};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push && !Rst) r_mem[r_wp] <= BusIn;
  end

  // Strobe/enable outputs are registered and updated on the transition into each state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tx     <= '0;
      r_rdn    <= 1'b1;
      r_wrn    <= 1'b1;
      r_bus_oe <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tx     <= DataIn[7:0];
            r_bus_oe <= 1'b1;
            r_state  <= TX_SETUP;
          end else if (data_ready && !w_full) begin
            r_rdn   <= 1'b0;
            r_cnt   <= '0;
            r_state <= RX_STROBE;
          end
        end
        RX_STROBE: begin
          if (r_cnt == RD_LAST) begin
            r_rdn   <= 1'b1;
            r_state <= RX_RECOVER;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_RECOVER: r_state <= IDLE;
        TX_SETUP: begin
          r_wrn   <= 1'b0;
          r_cnt   <= '0;
          r_state <= TX_STROBE;
        end
        TX_STROBE: begin
          if (r_cnt == WR_LAST) begin
            r_wrn   <= 1'b1;
            r_state <= TX_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_HOLD: begin
          r_bus_oe <= 1'b0;
          r_state  <= TX_WAIT_TBRE;
        end
        TX_WAIT_TBRE: if (tbre) r_state <= TX_WAIT_TSRE;
        TX_WAIT_TSRE: if (tsre) r_state <= IDLE;
        default: begin
          r_rdn    <= 1'b1;
          r_wrn    <= 1'b1;
          r_bus_oe <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ctrl.sv
// Directed + randomized bench for serial_ctrl; a queue-based UART/CPU model predicts
// bytes read, bytes transmitted, status bits and strobe widths.
module tb_serial_ctrl;

  localparam logic [15:0] DATA_A = 16'hBF00;
  localparam logic [15:0] STAT_A = 16'hBF01;
  localparam int RD = 2;
  localparam int WR = 2;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] DataOut;
  logic        Busy;
  logic        rdn;
  logic        wrn;
  logic        data_ready;
  logic        tbre;
  logic        tsre;
  logic [7:0]  BusOut;
  logic        BusOe;
  logic [7:0]  BusIn;

  int checks = 0;
  int failures = 0;
  byte unsigned uart_q[$];
  byte unsigned exp_rx[$];
  byte unsigned exp_tx[$];
  int rd_run = 0;
  int wr_run = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  logic [7:0] tx_cap = 8'h00;
  bit pend_pop = 1'b0;

  serial_ctrl #(
    .DATA_ADDR(DATA_A), .STAT_ADDR(STAT_A),
    .RD_CYCLES(RD), .WR_CYCLES(WR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Addr(Addr), .DataIn(DataIn),
    .MemRead(MemRead), .MemWrite(MemWrite), .DataOut(DataOut), .Busy(Busy),
    .rdn(rdn), .wrn(wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
    .BusOut(BusOut), .BusOe(BusOe), .BusIn(BusIn)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_uart();
    data_ready = (uart_q.size() != 0);
    BusIn = (uart_q.size() != 0) ? uart_q[0] : 8'h00;
  endtask

  // One clock: advance past the edge, update the model, watch the strobes.
  task automatic tick();
    int sz;
    sz = exp_rx.size();
    @(posedge Clk);
    #1;
    if (pend_pop) begin
      exp_rx.delete(0);
      pend_pop = 1'b0;
    end
    if (Rst) begin
      rd_run = 0;
      wr_run = 0;
      exp_rx.delete();
      exp_tx.delete();
    end else begin
      chk("never_both_low", 32'({rdn, wrn} != 2'b00), 32'd1);
      if (rdn == 1'b0) begin
        if (rd_run == 0) chk("rx_start_below_full", 32'(sz < DEPTH), 32'd1);
        chk("rx_bus_released", 32'(BusOe), 32'd0);
        rd_run++;
      end else if (rd_run > 0) begin
        chk("rdn_width", rd_run, RD);
        rd_pulses++;
        rd_run = 0;
        chk("rx_byte_present", 32'(uart_q.size() != 0), 32'd1);
        if (uart_q.size() != 0) exp_rx.push_back(uart_q.pop_front());
      end
      if (wrn == 1'b0) begin
        if (wr_run == 0) tx_cap = BusOut;
        chk("tx_bus_driven", 32'(BusOe), 32'd1);
        chk("tx_bus_stable", 32'(BusOut), 32'(tx_cap));
        wr_run++;
      end else if (wr_run > 0) begin
        chk("wrn_width", wr_run, WR);
        wr_pulses++;
        wr_run = 0;
        chk("tx_byte_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) chk("tx_byte", 32'(tx_cap), 32'(exp_tx.pop_front()));
      end
    end
    drive_uart();
  endtask

  task automatic load_data(input string tag);
    MemWrite = 1'b0;
    MemRead = 1'b1;
    Addr = DATA_A;
    #1;
    chk(tag, 32'(DataOut), (exp_rx.size() != 0) ? 32'({8'h00, exp_rx[0]}) : 32'd0);
    pend_pop = (exp_rx.size() != 0);
    tick();
    MemRead = 1'b0;
  endtask

  task automatic stat(input string tag, input logic [15:0] exp);
    MemWrite = 1'b0;
    MemRead = 1'b1;
    Addr = STAT_A;
    #1;
    chk(tag, 32'(DataOut), 32'(exp));
    MemRead = 1'b0;
  endtask

  initial begin
    logic [7:0] ew;
    logic [7:0] eo;
    logic [7:0] er;
    int p0;
    int w0;
    int op;
    logic [15:0] ra;

    Rst = 1'b1; Addr = '0; DataIn = '0; MemRead = 1'b0; MemWrite = 1'b0;
    tbre = 1'b0; tsre = 1'b0;
    drive_uart();
    tick(); tick();
    Rst = 1'b0;
    chk("rst_rdn", 32'(rdn), 32'd1);
    chk("rst_wrn", 32'(wrn), 32'd1);
    chk("rst_oe", 32'(BusOe), 32'd0);
    chk("rst_busout", 32'(BusOut), 32'd0);
    stat("rst_stat", 16'h0001);

    // Reset pulse in the middle of a write strobe
    MemWrite = 1'b1; Addr = DATA_A; DataIn = 16'h1241; #1;
    chk("t1_busy_idle", 32'(Busy), 32'd0);
    exp_tx.push_back(8'h41);
    tick();
    MemWrite = 1'b0;
    chk("t1_setup_oe", 32'(BusOe), 32'd1);
    chk("t1_setup_byte", 32'(BusOut), 32'h41);
    tick();
    chk("t1_strobe_wrn", 32'(wrn), 32'd0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("t1_wrn", 32'(wrn), 32'd1);
    chk("t1_oe", 32'(BusOe), 32'd0);
    chk("t1_busout", 32'(BusOut), 32'd0);
    stat("t1_stat", 16'h0001);
    MemWrite = 1'b1; Addr = DATA_A; DataIn = 16'h0000; #1;
    chk("t1_idle_busy", 32'(Busy), 32'd0);
    MemWrite = 1'b0;
    tick();

    // Single transmit, cycle by cycle
    ew = 8'b1111_1001; eo = 8'b0000_1111; er = 8'b1000_0000;
    MemWrite = 1'b1; Addr = DATA_A; DataIn = 16'hC355; #1;
    chk("t2_busy", 32'(Busy), 32'd0);
    exp_tx.push_back(8'h55);
    tick();
    MemWrite = 1'b0;
    chk("t2_byte", 32'(BusOut), 32'h55);
    for (int k = 1; k <= 8; k++) begin
      chk("t2_wrn", 32'(wrn), 32'(ew[k-1]));
      chk("t2_oe", 32'(BusOe), 32'(eo[k-1]));
      stat("t2_stat", {15'b0, er[k-1]});
      if (k == 6) begin tbre = 1'b1; tsre = 1'b1; end
      if (k < 8) tick();
    end
    tbre = 1'b0; tsre = 1'b0;

    // Second store held while the first is in flight
    MemWrite = 1'b1; Addr = DATA_A; DataIn = 16'h005A; #1;
    chk("t3_first_busy", 32'(Busy), 32'd0);
    exp_tx.push_back(8'h5A);
    tick();
    DataIn = 16'h0066;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("t3_busy", 32'(Busy), 32'(k < 8));
      if (k == 6) begin tbre = 1'b1; tsre = 1'b1; end
      if (k == 8) exp_tx.push_back(8'h66);
      tick();
    end
    MemWrite = 1'b0;
    chk("t3_oe", 32'(BusOe), 32'd1);
    chk("t3_byte", 32'(BusOut), 32'h66);
    repeat (7) tick();
    stat("t3_stat_idle", 16'h0001);

    // Two received bytes
    p0 = rd_pulses;
    uart_q.push_back(8'h31); uart_q.push_back(8'h32);
    drive_uart();
    tick();
    chk("t4_rdn_a", 32'(rdn), 32'd0);
    tick();
    chk("t4_rdn_b", 32'(rdn), 32'd0);
    tick();
    chk("t4_rdn_c", 32'(rdn), 32'd1);
    stat("t4_stat_avail", 16'h0003);
    for (int n = 0; n < 20 && rd_pulses < p0 + 2; n++) tick();
    chk("t4_two_pulses", rd_pulses - p0, 2);
    tick();
    load_data("t4_load_31");
    load_data("t4_load_32");
    load_data("t4_load_empty");
    chk("t4_pulses_total", rd_pulses - p0, 2);
    stat("t4_stat_empty", 16'h0001);

    // FIFO fills, chip keeps the rest
    p0 = rd_pulses;
    for (int i = 0; i < 6; i++) uart_q.push_back(8'(8'h40 + i));
    drive_uart();
    repeat (40) tick();
    chk("t5_four_pulses", rd_pulses - p0, 4);
    chk("t5_chip_left", uart_q.size(), 2);
    chk("t5_rdn_idle", 32'(rdn), 32'd1);
    stat("t5_stat", 16'h0003);
    load_data("t5_pop");
    repeat (10) tick();
    chk("t5_fifth_pulse", rd_pulses - p0, 5);
    for (int n = 0; n < 80; n++) begin
      if (exp_rx.size() == 0 && uart_q.size() == 0 && rd_run == 0) break;
      load_data("t5_drain");
    end
    chk("t5_drained", exp_rx.size() + uart_q.size(), 0);
    repeat (3) tick();

    // Store and data_ready in the same idle cycle: store wins
    tbre = 1'b1; tsre = 1'b1;
    p0 = rd_pulses; w0 = wr_pulses;
    uart_q.push_back(8'h99);
    drive_uart();
    MemWrite = 1'b1; Addr = DATA_A; DataIn = 16'h0077; #1;
    chk("t6_busy", 32'(Busy), 32'd0);
    exp_tx.push_back(8'h77);
    tick();
    MemWrite = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("t6_rdn", 32'(rdn), 32'(k != 8));
      if (k < 8) tick();
    end
    chk("t6_tx_done", wr_pulses - w0, 1);
    repeat (4) tick();
    chk("t6_rx_done", rd_pulses - p0, 1);
    load_data("t6_load_99");

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      tbre = ($urandom_range(0, 3) != 0);
      tsre = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0 && uart_q.size() < 8) begin
        uart_q.push_back(8'($urandom));
        drive_uart();
      end
      op = $urandom_range(0, 5);
      case (op)
        0: load_data("rnd_load");
        1: begin
          MemRead = 1'b1; Addr = STAT_A; #1;
          chk("rnd_stat_rx", 32'(DataOut[1]), 32'(exp_rx.size() != 0));
          chk("rnd_stat_hi", 32'(DataOut[15:2]), 32'd0);
          MemRead = 1'b0;
          tick();
        end
        2: begin
          MemWrite = 1'b1; Addr = DATA_A; DataIn = 16'($urandom); #1;
          if (!Busy) exp_tx.push_back(DataIn[7:0]);
          tick();
          MemWrite = 1'b0;
        end
        3: begin
          ra = 16'($urandom);
          if (ra == DATA_A) ra = STAT_A;
          MemWrite = 1'b1; Addr = ra; DataIn = 16'($urandom); #1;
          chk("rnd_other_busy", 32'(Busy), 32'd0);
          tick();
          MemWrite = 1'b0;
        end
        default: tick();
      endcase
    end

    tbre = 1'b1; tsre = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (exp_rx.size() == 0 && uart_q.size() == 0 && exp_tx.size() == 0 &&
          rd_run == 0 && wr_run == 0) break;
      load_data("drain_load");
    end
    repeat (10) tick();
    chk("end_tx_empty", exp_tx.size(), 0);
    chk("end_rx_empty", exp_rx.size(), 0);
    chk("end_uart_empty", uart_q.size(), 0);
    chk("end_rdn", 32'(rdn), 32'd1);
    chk("end_wrn", 32'(wrn), 32'd1);
    chk("end_oe", 32'(BusOe), 32'd0);
    stat("end_stat", 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
